// File: rtl/jtexterm_linebuf.sv
// Double-banked pixel line buffer: the draw engine fills the back bank while the front bank is
// scanned out at pxl_cen_i and erased behind the read pointer.
module jtexterm_linebuf #(
    parameter int unsigned   AW     = 9,
    parameter int unsigned   DW     = 9,
    parameter logic [DW-1:0] CLR    = '0,
    parameter logic [3:0]    TRANSP = 4'hF
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          pxl_cen_i,
    input  logic          hs_i,
    input  logic          lhbl_i,
    input  logic          flip_i,
    input  logic [AW-1:0] hdump_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [DW-1:0] wr_data_i,
    input  logic          wr_we_i,
    input  logic          draw_done_i,
    output logic          line_start_o,
    output logic          overrun_o,
    output logic [DW-1:0] col_addr_o
);
    localparam int unsigned Depth = 2 ** AW;

    logic          hs_l_q, hs_l_d;
    logic          wsel_q, wsel_d;
    logic          busy_q, busy_d;
    logic          line_start_q, line_start_d;
    logic          overrun_q, overrun_d;
    logic [DW-1:0] col_addr_q, col_addr_d;
    logic          rd_pend_q, rd_pend_d;
    logic          rd_bank_q, rd_bank_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d;
    logic [DW-1:0] rd_data_q;
    logic          hold_vld_q, hold_vld_d;
    logic          hold_bank_q, hold_bank_d;
    logic [AW-1:0] hold_addr_q, hold_addr_d;
    logic [DW-1:0] hold_data_q, hold_data_d;

    logic          swap, draw_ok, rd_now, hold_used, in_used;
    logic [1:0]    we;
    logic [AW-1:0] waddr [2];
    logic [DW-1:0] wdata [2];
    logic [DW-1:0] mem0 [Depth];
    logic [DW-1:0] mem1 [Depth];

    always_comb begin
        swap         = hs_i & ~hs_l_q;
        draw_ok      = wr_we_i & busy_q & (wr_data_i[3:0] != TRANSP);
        rd_now       = pxl_cen_i & lhbl_i;
        hs_l_d       = hs_i;
        wsel_d       = wsel_q ^ swap;
        line_start_d = swap;
        // A draw_done landing in the swap cycle still counts as finishing the old line.
        overrun_d    = swap ? (busy_q & ~draw_done_i) : overrun_q;
        busy_d       = swap ? 1'b1 : (draw_done_i ? 1'b0 : busy_q);

        rd_pend_d  = rd_now;
        rd_addr_d  = rd_now ? (flip_i ? ~hdump_i : hdump_i) : rd_addr_q;
        rd_bank_d  = rd_now ? ~wsel_q : rd_bank_q;
        col_addr_d = pxl_cen_i ? (lhbl_i ? rd_data_q : CLR) : col_addr_q;

        // Per-bank write port: erase first, then the held draw, then the incoming draw.
        hold_used = 1'b0;
        in_used   = 1'b0;
        we        = '0;
        for (int b = 0; b < 2; b++) begin
            waddr[b] = rd_addr_q;
            wdata[b] = CLR;
            if (rd_pend_q && rd_bank_q == 1'(b)) begin
                we[b] = 1'b1;
            end else if (hold_vld_q && hold_bank_q == 1'(b)) begin
                we[b]     = 1'b1;
                waddr[b]  = hold_addr_q;
                wdata[b]  = hold_data_q;
                hold_used = 1'b1;
            end else if (draw_ok && wsel_q == 1'(b)) begin
                we[b]    = 1'b1;
                waddr[b] = wr_addr_i;
                wdata[b] = wr_data_i;
                in_used  = 1'b1;
            end
        end

        hold_vld_d  = hold_vld_q;
        hold_bank_d = hold_bank_q;
        hold_addr_d = hold_addr_q;
        hold_data_d = hold_data_q;
        if (!hold_vld_q || hold_used) begin
            hold_vld_d = draw_ok && !in_used;
            if (draw_ok && !in_used) begin
                hold_bank_d = wsel_q;
                hold_addr_d = wr_addr_i;
                hold_data_d = wr_data_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hs_l_q       <= 1'b0;
            wsel_q       <= 1'b0;
            busy_q       <= 1'b0;
            line_start_q <= 1'b0;
            overrun_q    <= 1'b0;
            col_addr_q   <= CLR;
            rd_pend_q    <= 1'b0;
            rd_bank_q    <= 1'b0;
            rd_addr_q    <= '0;
            rd_data_q    <= CLR;
            hold_vld_q   <= 1'b0;
            hold_bank_q  <= 1'b0;
            hold_addr_q  <= '0;
            hold_data_q  <= CLR;
        end else begin
            hs_l_q       <= hs_l_d;
            wsel_q       <= wsel_d;
            busy_q       <= busy_d;
            line_start_q <= line_start_d;
            overrun_q    <= overrun_d;
            col_addr_q   <= col_addr_d;
            rd_pend_q    <= rd_pend_d;
            rd_bank_q    <= rd_bank_d;
            rd_addr_q    <= rd_addr_d;
            // Sample only on the read slot; the same edge erases this location.
            if (rd_pend_q) begin
                rd_data_q <= rd_bank_q ? mem1[rd_addr_q] : mem0[rd_addr_q];
            end
            hold_vld_q   <= hold_vld_d;
            hold_bank_q  <= hold_bank_d;
            hold_addr_q  <= hold_addr_d;
            hold_data_q  <= hold_data_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (we[0]) begin
            mem0[waddr[0]] <= wdata[0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (we[1]) begin
            mem1[waddr[1]] <= wdata[1];
        end
    end

    assign line_start_o = line_start_q;
    assign overrun_o    = overrun_q;
    assign col_addr_o   = col_addr_q;

endmodule
